// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state
// encodings, default widths and the control-word conventions.
package pipeline_ctrl_pkg;

  localparam int STATE_W      = 2;
  localparam int RA_W_DEFAULT = 4;
  localparam int STALL_CNT_W  = 16;

  // Legacy-compatible state encodings; 2'd3 is illegal and recovers to RUN.
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd0;
  localparam logic [STATE_W-1:0] ST_MD_BUSY = 2'd1;
  localparam logic [STATE_W-1:0] ST_HALT    = 2'd2;

  // One bit per pipeline-buffer control driven by the sequencer.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  // Bubble convention: every control bit zero (nothing loads, nothing flushes).
  localparam ctrl_t CTRL_BUBBLE = '0;

  // Normal flow: all buffers advance, nothing is flushed.
  localparam ctrl_t CTRL_PASS = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                  idex_write: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0};

  // Freeze the front end and insert a bubble into EX (load-use and HALT).
  function automatic ctrl_t front_stall();
    ctrl_t c;
    c            = CTRL_PASS;
    c.pc_write   = 1'b0;
    c.ifid_write = 1'b0;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Hold everything up to EX while a multi-cycle op occupies it; EX/MEM gets bubbles.
  function automatic ctrl_t md_stall();
    ctrl_t c;
    c             = CTRL_PASS;
    c.pc_write    = 1'b0;
    c.ifid_write  = 1'b0;
    c.idex_write  = 1'b0;
    c.exmem_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and buffer control outputs seen by the
// hazard sequencer. master = pipeline datapath side, slave = sequencer.
interface pipeline_hazard_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEFAULT
);
  logic [RA_W-1:0]        idRR1;
  logic [RA_W-1:0]        idRR2;
  logic                   idUsesRR2;
  logic                   idHalt;
  logic [RA_W-1:0]        idexWAddr;
  logic                   idexMemRead;
  logic                   exBranchTaken;
  logic                   exMulDiv;
  logic                   resume;
  logic                   pcWrite;
  logic                   ifidWrite;
  logic                   ifidFlush;
  logic                   idexWrite;
  logic                   idexFlush;
  logic                   exmemFlush;
  logic                   busy;
  logic [STATE_W-1:0]     state;
  logic [STALL_CNT_W-1:0] stallCount;

  modport master (
    output idRR1, idRR2, idUsesRR2, idHalt, idexWAddr, idexMemRead,
           exBranchTaken, exMulDiv, resume,
    input  pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemFlush,
           busy, state, stallCount
  );

  modport slave (
    input  idRR1, idRR2, idUsesRR2, idHalt, idexWAddr, idexMemRead,
           exBranchTaken, exMulDiv, resume,
    output pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemFlush,
           busy, state, stallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_md_cycle_counter.sv
// Down-counter tracking the remaining stall cycles of a multiply/divide op.
module md_cycle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             is_zero
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Load has priority; decrement never wraps below zero.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Counter register, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign is_zero = (count_reg == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, multi-cycle multiply/divide occupancy and HALT.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 4,
  parameter int RA_W      = RA_W_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  // A single-cycle op needs no sequencing at all.
  localparam bit MD_MULTI = (MD_CYCLES >= 2);
  // Stalls remaining after the first one, issued from RUN.
  localparam int MD_LOAD_INT = MD_MULTI ? (MD_CYCLES - 2) : 0;
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LOAD_INT);

  logic [STATE_W-1:0]     state_reg;
  logic [STATE_W-1:0]     state_next;
  logic [STALL_CNT_W-1:0] stall_count_reg;
  ctrl_t                  ctrl;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic                   load_use;

  logic [RA_W-1:0] id_rr1;
  logic [RA_W-1:0] id_rr2;
  logic [RA_W-1:0] idex_waddr;

  assign id_rr1     = bus.idRR1;
  assign id_rr2     = bus.idRR2;
  assign idex_waddr = bus.idexWAddr;

  // A load in EX whose destination is read by the instruction in ID.
  assign load_use = bus.idexMemRead &&
                    ((idex_waddr == id_rr1) || (bus.idUsesRR2 && (idex_waddr == id_rr2)));

  md_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_md_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (MD_LOAD),
    .dec        (cnt_dec),
    .is_zero    (cnt_zero)
  );

  // Mealy decode of buffer controls and next state from state, counter and inputs.
  always_comb begin
    ctrl       = CTRL_PASS;
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (reset) begin
      ctrl       = CTRL_BUBBLE;
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus.exBranchTaken) begin
            // Kill the two wrong-path instructions; PC takes the target.
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (bus.exMulDiv && MD_MULTI) begin
            ctrl       = md_stall();
            cnt_load   = 1'b1;
            state_next = ST_MD_BUSY;
          end else if (load_use) begin
            ctrl = front_stall();
          end else if (bus.idHalt) begin
            ctrl       = front_stall();
            state_next = ST_HALT;
          end
        end
        ST_MD_BUSY: begin
          // Branch and multiply inputs are stale here: the op still owns EX.
          if (!cnt_zero) begin
            ctrl    = md_stall();
            cnt_dec = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_HALT: begin
          ctrl = front_stall();
          if (bus.resume) begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (!ctrl.pc_write && (stall_count_reg != {STALL_CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign bus.pcWrite    = ctrl.pc_write;
  assign bus.ifidWrite  = ctrl.ifid_write;
  assign bus.ifidFlush  = ctrl.ifid_flush;
  assign bus.idexWrite  = ctrl.idex_write;
  assign bus.idexFlush  = ctrl.idex_flush;
  assign bus.exmemFlush = ctrl.exmem_flush;
  assign bus.busy       = !reset && (state_reg != ST_RUN);
  assign bus.state      = state_reg;
  assign bus.stallCount = stall_count_reg;

endmodule
